id_fetch_buffer: RTL

- Parametrised instruction holding queue plus ID-stage pipeline register, between instruction-cache return and decode.
- Replaces the single-entry "one instruction held during stall" scheme with a DEPTH-entry FIFO, so fetch can keep returning instructions while ID is stalled.
- Carries {excepttype, pc, inst} per entry.
- Implements bubble insertion, flush, and branch kill on the ID register.

---
 rtl/id_fetch_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/id_fetch_buffer.sv
// Instruction holding queue in front of the ID-stage pipeline register.
// Fetch keeps filling the queue while ID is stalled; the ID register drains it in order.
module id_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       stall_id,
  input  logic                       stall_ex,
  input  logic                       br_kill,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [EXC_W-1:0]           out_exc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = EXC_W + PC_W + INST_W;

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          id_valid_reg, id_valid_next;
  logic [EW-1:0] id_word_reg, id_word_next;
  logic          push;
  logic          kill;
  logic          full_w;
  logic          empty_w;
  logic [EW-1:0] in_word;
  logic [EW-1:0] head_word;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full_w    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty_w   = (wr_ptr_reg == rd_ptr_reg);
  assign in_word   = {in_exc, in_pc, in_inst};
  assign head_word = mem[rd_ptr_reg[AW-1:0]];
  // A branch kill arriving while stalled is ignored; the branch unit repeats it.
  assign kill      = flush | (br_kill & ~stall_id & ~stall_ex);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    id_valid_next = id_valid_reg;
    id_word_next  = id_word_reg;
    push          = 1'b0;
    if (kill) begin
      rd_ptr_next   = wr_ptr_reg;
      id_valid_next = 1'b0;
      id_word_next  = '0;
    end else if (stall_id) begin
      push = in_valid & ~full_w;
      if (!stall_ex) begin
        id_valid_next = 1'b0;
        id_word_next  = '0;
      end
    end else if (!empty_w) begin
      id_valid_next = 1'b1;
      id_word_next  = head_word;
      rd_ptr_next   = rd_ptr_reg + 1'b1;
      push          = in_valid & ~full_w;
    end else if (in_valid) begin
      id_valid_next = 1'b1;
      id_word_next  = in_word;
    end else begin
      id_valid_next = 1'b0;
      id_word_next  = '0;
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      id_valid_reg <= 1'b0;
      id_word_reg  <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      id_valid_reg <= id_valid_next;
      id_word_reg  <= id_word_next;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_word;
    end
  end

  assign in_ready  = ~full_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = wr_ptr_reg - rd_ptr_reg;
  assign out_valid = id_valid_reg;
  assign out_inst  = id_word_reg[INST_W-1:0];
  assign out_pc    = id_word_reg[INST_W +: PC_W];
  assign out_exc   = id_word_reg[INST_W+PC_W +: EXC_W];

endmodule
